// File: rtl/dft_resp_misr_if.sv
// Response-capture bus between the DFT wrapper and dft_resp_misr.
// The slave side is the MISR block; the master side drives strobes and response words.
interface dft_resp_misr_if #(
  parameter int CW = 9
);
  logic          en;
  logic          clr;
  logic          next;
  logic [15:0]   Y0;
  logic [15:0]   Y1;
  logic [15:0]   Y2;
  logic [15:0]   Y3;
  logic [63:0]   signature;
  logic [CW-1:0] pat_count;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [1:0]    state_dbg;

  modport slave (
    input  en, clr, next, Y0, Y1, Y2, Y3,
    output signature, pat_count, busy, done, pass, timeout, state_dbg
  );

  modport master (
    output en, clr, next, Y0, Y1, Y2, Y3,
    input  signature, pat_count, busy, done, pass, timeout, state_dbg
  );
endinterface

// File: rtl/dft_resp_misr.sv
// 64-bit MISR response compactor: one capture per rising edge of next, golden compare at the end.
// Optional watchdog on the gap between captures is enabled with `define DFT_RESP_TIMEOUT_EN.
module dft_resp_misr #(
  parameter int          NUM_PATTERNS = 256,
  parameter logic [63:0] SEED         = 64'h0000_0000_0000_0001,
  parameter logic [63:0] GOLDEN       = 64'h0,
  parameter int          TIMEOUT      = 64,
  parameter int          CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  dft_resp_misr_if.slave bus
);
  // Handshake: there is no ready; a capture is the rising edge of next, and the
  // response words must be stable in the cycle that edge is first seen high.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS);

  state_t        state, state_nx;
  logic [63:0]   sig, sig_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          next_d;
  logic          pass_r, pass_nx;
  logic          cap;
  logic [63:0]   data;
  logic [63:0]   sig_step;

  function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] d);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb} ^ d;
  endfunction

  assign cap      = bus.next & ~next_d;
  assign data     = {bus.Y0, bus.Y1, bus.Y2, bus.Y3};
  assign sig_step = misr_step(sig, data);

`ifdef DFT_RESP_TIMEOUT_EN
  localparam int            WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT);
  logic [WW-1:0] wd, wd_nx;
  logic          tmo_r, tmo_nx;
`endif

  always_comb begin
    state_nx = state;
    sig_nx   = sig;
    cnt_nx   = cnt;
    pass_nx  = pass_r;
`ifdef DFT_RESP_TIMEOUT_EN
    wd_nx    = wd;
    tmo_nx   = tmo_r;
`endif
    if (bus.clr) begin
      state_nx = IDLE;
      sig_nx   = SEED;
      cnt_nx   = '0;
      pass_nx  = 1'b0;
`ifdef DFT_RESP_TIMEOUT_EN
      wd_nx    = '0;
      tmo_nx   = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            state_nx = RUN;
`ifdef DFT_RESP_TIMEOUT_EN
            wd_nx    = '0;
`endif
          end
        end
        RUN: begin
          if (cap) begin
            sig_nx = sig_step;
            cnt_nx = cnt + 1'b1;
`ifdef DFT_RESP_TIMEOUT_EN
            wd_nx  = '0;
`endif
            // Final capture: pass is decided from the signature being registered now.
            if (cnt_nx == LAST) begin
              state_nx = DONE;
              pass_nx  = (sig_step == GOLDEN);
            end
          end
`ifdef DFT_RESP_TIMEOUT_EN
          else begin
            wd_nx = wd + 1'b1;
            if (wd_nx == WD_LAST) begin
              state_nx = DONE;
              tmo_nx   = 1'b1;
              pass_nx  = 1'b0;
            end
          end
`endif
        end
        DONE: begin
          state_nx = DONE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sig    <= SEED;
      cnt    <= '0;
      next_d <= 1'b0;
      pass_r <= 1'b0;
`ifdef DFT_RESP_TIMEOUT_EN
      wd     <= '0;
      tmo_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      sig    <= sig_nx;
      cnt    <= cnt_nx;
      next_d <= bus.next;
      pass_r <= pass_nx;
`ifdef DFT_RESP_TIMEOUT_EN
      wd     <= wd_nx;
      tmo_r  <= tmo_nx;
`endif
    end
  end

  assign bus.signature = sig;
  assign bus.pat_count = cnt;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_r;
  assign bus.state_dbg = state;
`ifdef DFT_RESP_TIMEOUT_EN
  assign bus.timeout   = tmo_r;
`else
  assign bus.timeout   = 1'b0;
`endif
endmodule

// File: doc/dft_resp_misr.md
Name: dft_resp_misr

Overview:
- Response-side counterpart of the on-chip DFT stimulus controller.
- Samples the four 16-bit DUT response words once per pattern, on each rising edge of the stimulus controller's `next` strobe.
- Compacts the samples into a 64-bit MISR signature.
- After NUM_PATTERNS captures, compares the signature against a golden value and reports done/pass.
- Sits beside the stimulus controller in the DFT wrapper, between the DUT outputs and the test status pins.

Parameters:
- NUM_PATTERNS, 256, number of captures per test run (≥1).
- SEED, 64'h0000_0000_0000_0001, MISR value after reset or clear.
- GOLDEN, 64'h0, expected final signature.
- TIMEOUT, 64, max cycles between `next` rising edges (used only with the optional feature).
- CW, $clog2(NUM_PATTERNS+1), derived pattern-counter width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- en  in  1  level; run enable, sampled in IDLE.
- clr  in  1  synchronous clear back to IDLE/SEED.
- next  in  1  pattern-advance strobe from the stimulus controller; a rising edge marks a stable response.
- Y0, Y1, Y2, Y3  in  16 each  DUT response words.
- signature  out  64  current MISR value.
- pat_count  out  CW  captures taken this run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when signature == GOLDEN.
- timeout  out  1  watchdog fired (tied 0 without the optional feature).

Behaviour:
- Reset (rst=0, asynchronous) gives:
  - state=IDLE, signature=SEED, pat_count=0, next_d=0;
  - busy=0, done=0, pass=0, timeout=0.
- Reset mid-run aborts the run with no residual state.
- Edge detect:
  - next_d is a registered copy of `next`; `cap = next & ~next_d`.
  - A `next` held high counts as one capture only.
- Data word: D = {Y0,Y1,Y2,Y3}, with Y0 in bits [63:48].
- MISR step:
  - fb = s[63]^s[62]^s[60]^s[59] (polynomial x^64+x^63+x^61+x^60+1).
  - s' = {s[62:0],fb} ^ D.
- FSM:
  - IDLE:
    - busy=0; captures ignored.
    - en=1 → RUN the next cycle. signature stays SEED and pat_count stays 0.
  - RUN:
    - busy=1.
    - On cap: signature<=step, pat_count<=pat_count+1.
    - If that capture makes pat_count==NUM_PATTERNS → DONE the next cycle, with the final signature already registered.
    - en=0 in RUN does not pause the run; only clr or rst aborts it.
  - DONE:
    - done=1; pass = (signature==GOLDEN), registered on entry.
    - Further captures are ignored; signature and pat_count are frozen.
    - Stays in DONE until clr or rst.
- clr=1 (any state) → IDLE, signature=SEED, pat_count=0, flags 0.
  - clr has priority over cap in the same cycle.
  - en=1 with clr=1 stays in IDLE.
- Latency: a capture edge in cycle n is visible on signature in cycle n+1. done/pass assert in cycle n+1 after the final capture.
- No wrap: pat_count saturates at NUM_PATTERNS.

Optional Feature:
- Macro: DFT_RESP_TIMEOUT_EN.
- Defined:
  - A watchdog counter is cleared on entry to RUN and on every cap, and increments each RUN cycle.
  - Reaching TIMEOUT → DONE with timeout=1, pass=0, signature frozen.
  - timeout clears only on clr or rst.
- Not defined:
  - No watchdog logic; timeout is tied 0.
  - RUN waits for `next` indefinitely.

Test Plan:
- SEED=64'h1, GOLDEN=64'h2, NUM_PATTERNS=1; reset, en=1, pulse `next` with all Y=0 → signature=64'h2 one cycle later; done=1, pass=1, pat_count=1.
- SEED=64'h8000_0000_0000_0000, NUM_PATTERNS=1, Y0=16'hFFFF, others 0 → signature=64'hFFFF_0000_0000_0001, done=1; pass=0 with GOLDEN=0.
- NUM_PATTERNS=3, `next` held high 10 cycles, then low, then 2 more pulses → pat_count steps 1,2,3 only on the rising edges; done asserts after the third edge; a fourth pulse leaves signature unchanged.
- Mid-run (pat_count=2), drive rst=0 between clock edges → outputs return to reset values immediately. Repeat with clr=1 coincident with a `next` edge → IDLE, signature=SEED, pat_count=0.
- DFT_RESP_TIMEOUT_EN, TIMEOUT=64: en=1, no `next` edges → timeout=1, done=1, pass=0 after 64 RUN cycles. With the macro undefined, the same stimulus → busy stays 1 and timeout stays 0.
